// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready
// handshaking, a 2-entry skid buffer and a synchronous bubble-inserting flush.
//
// Handshake: an entry moves across a port on a posedge where both valid and
// ready are high (in_fire = in_valid & in_ready, out_fire = out_valid &
// out_ready). valid, once raised, holds its data until the transfer fires.
// in_ready and out_valid come straight from flops, so neither depends
// combinationally on the opposite side of the stage.
module pipe_stage_reg #(
    parameter int                  INSTR_W   = 14,
    parameter int                  CTRL_W    = 19,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
    parameter logic [CTRL_W-1:0]   NOP_CTRL  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [CTRL_W-1:0]  ctrl_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic [1:0]         occupancy
);

    // Encoding equals the number of held entries, so the state doubles as
    // the occupancy output and the FSM is visible to checkers directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic in_ready_q;
    logic out_valid_q;

    logic in_fire;
    logic out_fire;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // Entry storage; deliberately not reset, validity lives in the state.
    logic [INSTR_W-1:0] main_instr;
    logic [CTRL_W-1:0]  main_ctrl;
    logic [INSTR_W-1:0] skid_instr;
    logic [CTRL_W-1:0]  skid_ctrl;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and data-steering decode; flush overrides every transition.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // An entry accepted this cycle is dropped; an out_fire already
            // happened downstream, so nothing here needs to undo it.
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        next_state   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid  = 1'b1;
                        next_state = TWO;
                    end else if (out_fire) begin
                        next_state = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        next_state     = ONE;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // State plus the registered handshake flags derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state != TWO);
            out_valid_q <= (next_state != EMPTY);
        end
    end

    // Entry data movement: input to main or skid, skid forward into main.
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_instr <= instr_in;
            main_ctrl  <= ctrl_in;
        end else if (load_main_skid) begin
            main_instr <= skid_instr;
            main_ctrl  <= skid_ctrl;
        end
        if (load_skid) begin
            skid_instr <= instr_in;
            skid_ctrl  <= ctrl_in;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = state;

    // Bubbles present NOP values so stale entry data never leaks downstream.
    assign instr_out = out_valid_q ? main_instr : NOP_INSTR;
    assign ctrl_out  = out_valid_q ? main_ctrl  : NOP_CTRL;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vectors with hand-computed expectations,
// a delivery-order scoreboard, and a second wide-parameter instance.
module tb_pipe_stage_reg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- default-width instance ----------------
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [13:0] instr_in, instr_out;
    logic [18:0] ctrl_in, ctrl_out;
    logic [1:0]  occupancy;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_out(instr_out), .ctrl_out(ctrl_out),
        .occupancy(occupancy)
    );

    // ---------------- wide instance ----------------
    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [31:0] w_instr_in, w_instr_out;
    logic [23:0] w_ctrl_in, w_ctrl_out;
    logic [1:0]  w_occupancy;

    pipe_stage_reg #(
        .INSTR_W(32), .CTRL_W(24), .NOP_INSTR(32'h0000_0013), .NOP_CTRL(24'h0)
    ) dut_w (
        .clk(clk), .rst(rst), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .instr_in(w_instr_in), .ctrl_in(w_ctrl_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .instr_out(w_instr_out), .ctrl_out(w_ctrl_out),
        .occupancy(w_occupancy)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] ctrl_of(input logic [13:0] i);
        return {i[4:0], i};
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int          delivered_33 = 0;

    // Sampled mid-cycle: inputs were driven 1 time unit after the posedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_entry", {31'd0, instr_out}, 64'hFFFF);
                end else begin
                    check("sb_order", {instr_out, ctrl_out}, exp_q.pop_front());
                end
                if (instr_out == 14'h33) delivered_33++;
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({instr_in, ctrl_of(instr_in)});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [13:0] i, input logic ordy, input logic fl);
        in_valid  = v;
        instr_in  = i;
        ctrl_in   = ctrl_of(i);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic check_status(input string tag, input logic ov, input logic ir,
                                input logic [1:0] occ, input logic [13:0] ins);
        check({tag, "_out_valid"}, {63'd0, out_valid}, {63'd0, ov});
        check({tag, "_in_ready"},  {63'd0, in_ready},  {63'd0, ir});
        check({tag, "_occupancy"}, {62'd0, occupancy}, {62'd0, occ});
        check({tag, "_instr_out"}, {50'd0, instr_out}, {50'd0, ins});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
        w_instr_in = '0; w_ctrl_in = '0;
        #12;
        check_status("reset", 1'b0, 1'b1, 2'd0, 14'h0);
        check("reset_ctrl_out", {45'd0, ctrl_out}, 64'd0);
        check("wide_idle_instr", {32'd0, w_instr_out}, 64'h13);
        step();
        rst = 1'b0;

        // Wide instance: full-width data through, NOP value when idle.
        w_in_valid = 1'b1; w_out_ready = 1'b1;
        w_instr_in = 32'hDEAD_BEEF; w_ctrl_in = 24'hA5_C3F0;
        step();
        check("wide_instr", {32'd0, w_instr_out}, 64'hDEAD_BEEF);
        check("wide_ctrl",  {40'd0, w_ctrl_out},  64'hA5_C3F0);
        w_in_valid = 1'b0;
        step();
        check("wide_bubble_instr", {32'd0, w_instr_out}, 64'h13);
        check("wide_bubble_valid", {63'd0, w_out_valid}, 64'd0);

        // Streaming: one per cycle, 1-cycle latency, occupancy stays at 1.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 14'(i), 1'b1, 1'b0);
            step();
            check_status("stream", 1'b1, 1'b1, 2'd1, 14'(i));
        end
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        step();
        check_status("stream_drain", 1'b0, 1'b1, 2'd0, 14'h0);

        // Stall absorbed by the skid entry, then released in order.
        drive(1'b1, 14'h0A, 1'b1, 1'b0);
        step();
        check_status("stall_a", 1'b1, 1'b1, 2'd1, 14'h0A);
        drive(1'b1, 14'h0B, 1'b0, 1'b0);
        step();
        check_status("stall_skid", 1'b1, 1'b0, 2'd2, 14'h0A);
        drive(1'b1, 14'h0C, 1'b0, 1'b0);
        step();
        check_status("stall_hold", 1'b1, 1'b0, 2'd2, 14'h0A);
        drive(1'b1, 14'h0C, 1'b1, 1'b0);
        step();
        check_status("stall_rel_b", 1'b1, 1'b1, 2'd1, 14'h0B);
        step();
        check_status("stall_rel_c", 1'b1, 1'b1, 2'd1, 14'h0C);
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        step();
        check_status("stall_drain", 1'b0, 1'b1, 2'd0, 14'h0);

        // Flush from TWO with a concurrent input: everything discarded.
        drive(1'b1, 14'h21, 1'b0, 1'b0);
        step();
        drive(1'b1, 14'h22, 1'b0, 1'b0);
        step();
        check_status("flush_pre", 1'b1, 1'b0, 2'd2, 14'h21);
        drive(1'b1, 14'h23, 1'b0, 1'b1);
        step();
        check_status("flush_two", 1'b0, 1'b1, 2'd0, 14'h0);
        check("flush_two_ctrl", {45'd0, ctrl_out}, 64'd0);
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        step();
        check_status("flush_two_after", 1'b0, 1'b1, 2'd0, 14'h0);

        // Flush coinciding with out_fire: the entry is delivered exactly once.
        drive(1'b1, 14'h33, 1'b0, 1'b0);
        step();
        check_status("flushof_pre", 1'b1, 1'b1, 2'd1, 14'h33);
        drive(1'b0, 14'h0, 1'b1, 1'b1);
        step();
        check_status("flushof", 1'b0, 1'b1, 2'd0, 14'h0);
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        step();
        check_status("flushof_after", 1'b0, 1'b1, 2'd0, 14'h0);
        check("flushof_count", 64'(delivered_33), 64'd1);

        // Asynchronous reset mid-cycle while holding two entries.
        drive(1'b1, 14'h41, 1'b0, 1'b0);
        step();
        drive(1'b1, 14'h42, 1'b0, 1'b0);
        step();
        check_status("rst_pre", 1'b1, 1'b0, 2'd2, 14'h41);
        #2;
        rst = 1'b1;
        #1;
        check_status("rst_async", 1'b0, 1'b1, 2'd0, 14'h0);
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b1, 14'h55, 1'b1, 1'b0);
        step();
        check_status("rst_resume", 1'b1, 1'b1, 2'd1, 14'h55);
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        step();
        step();
        check_status("final_idle", 1'b0, 1'b1, 2'd0, 14'h0);
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
